// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, start-up sequencing and the IF/ID pipeline register.
// Fetches from a zero-latency instruction memory and flags misaligned or out-of-range fetches.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [31:0] rom_inst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StReset, StStart, StRun} state_e;

  state_e      state_q, state_d;
  logic        rom_ce_q;
  logic        run;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_err_q, id_err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fetch_err;

  // State register; rom_ce is flopped from the next state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReset;
      rom_ce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rom_ce_q <= (state_d == StRun);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StStart;
      StStart: state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    run    = (state_q == StRun);
    rom_ce = rom_ce_q;
  end

  assign rom_addr  = pc_q;
  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q >= 32'(IMEM_BYTES));

  // flush outranks stall_if; a branch is only accepted once the stall clears.
  always_comb begin
    pc_d = pc_q;
    if (run) begin
      if (flush)            pc_d = new_pc;
      else if (stall_if)    pc_d = pc_q;
      else if (branch_flag) pc_d = branch_target;
      else                  pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_err_d  = id_err_q;
    cnt_d     = cnt_q;
    if (flush || !run) begin
      id_pc_d   = '0;
      id_inst_d = '0;
      id_err_d  = 1'b0;
    end else if (stall_id) begin
      id_pc_d   = id_pc_q;
    end else if (stall_if) begin
      id_pc_d   = '0;
      id_inst_d = '0;
      id_err_d  = 1'b0;
    end else begin
      id_pc_d   = pc_q;
      id_inst_d = fetch_err ? 32'd0 : rom_inst;
      id_err_d  = fetch_err;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      id_pc_q   <= '0;
      id_inst_q <= '0;
      id_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_err_q  <= id_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign id_pc        = id_pc_q;
  assign id_inst      = id_inst_q;
  assign id_fetch_err = id_err_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 8192;

  logic        clk, rst, stall_if, stall_id, branch_flag, flush;
  logic [31:0] branch_target, new_pc, rom_inst;
  logic        rom_ce, id_fetch_err;
  logic [31:0] rom_addr, id_pc, id_inst, fetch_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state; m_since counts non-reset edges since the last reset, saturating at 2.
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic        m_err;
  int          m_since;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
    .branch_flag(branch_flag), .branch_target(branch_target), .flush(flush),
    .new_pc(new_pc), .rom_inst(rom_inst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .id_pc(id_pc), .id_inst(id_inst), .id_fetch_err(id_fetch_err),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word[i] = i; out-of-range reads return junk that must never reach IF/ID.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'(IMEM_BYTES)) return a >> 2;
    return 32'hDEAD_BEEF;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall_if = 1'b0; stall_id = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    branch_target = '0; new_pc = '0;
  endtask

  task automatic model_edge();
    logic        running, ferr;
    running = (m_since >= 2);
    if (rst) begin
      m_pc = RESET_PC; m_since = 0; m_id_pc = 0; m_id_inst = 0; m_err = 0; m_cnt = 0;
      return;
    end
    ferr = (m_pc % 4 != 0) || (m_pc >= 32'(IMEM_BYTES));
    if (flush || !running) begin
      m_id_pc = 0; m_id_inst = 0; m_err = 0;
    end else if (!stall_id) begin
      if (stall_if) begin
        m_id_pc = 0; m_id_inst = 0; m_err = 0;
      end else begin
        m_id_pc = m_pc; m_id_inst = ferr ? 0 : rom_word(m_pc); m_err = ferr;
        m_cnt = m_cnt + 1;
      end
    end
    if (running) begin
      if (flush) m_pc = new_pc;
      else if (!stall_if) m_pc = branch_flag ? branch_target : m_pc + 4;
    end
    if (m_since < 2) m_since++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rom_ce", 32'(rom_ce), 32'(m_since >= 2));
    chk("rom_addr", rom_addr, m_pc);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_inst", id_inst, m_id_inst);
    chk("id_fetch_err", 32'(id_fetch_err), 32'(m_err));
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    idle();
    m_pc = 0; m_since = 0; m_id_pc = 0; m_id_inst = 0; m_err = 0; m_cnt = 0;
    // Reset and start-up sequence, then free-run.
    rst = 1'b1; step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    // Run to pc=0x10 region, then a two-cycle stall_if.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) step();
    chk("reach_pc10", rom_addr, 32'h10);
    stall_if = 1'b1; step(); step();
    stall_if = 1'b0; step(); step();
    // stall_id held for 3 cycles.
    stall_id = 1'b1; step(); step(); step();
    stall_id = 1'b0; step();
    // Branch concurrent with stall_if; held until accepted.
    branch_flag = 1'b1; branch_target = 32'h100; stall_if = 1'b1; step();
    stall_if = 1'b0; step();
    branch_flag = 1'b0; step(); step();
    // Flush with both stalls asserted.
    flush = 1'b1; new_pc = 32'h20; stall_if = 1'b1; stall_id = 1'b1; step();
    idle(); step(); step();
    // Misaligned and out-of-range fetches.
    branch_flag = 1'b1; branch_target = 32'h102; step();
    branch_flag = 1'b0; step(); step();
    branch_flag = 1'b1; branch_target = 32'h2000; step();
    branch_flag = 1'b0; step(); step();
    // PC wraps modulo 2^32.
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC; step();
    branch_flag = 1'b0; step(); step(); step();
    // Reset mid-operation overrides everything else.
    rst = 1'b1; flush = 1'b1; new_pc = 32'h40; branch_flag = 1'b1; step();
    idle(); step(); step(); step();
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      stall_if    = ($urandom_range(0, 3) == 0);
      stall_id    = ($urandom_range(0, 3) == 0);
      branch_flag = ($urandom_range(0, 5) == 0);
      branch_target = ($urandom_range(0, 2100) << 2) | (($urandom_range(0, 9) == 0) ? 2 : 0);
      new_pc        = $urandom_range(0, 2047) << 2;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 Parameter IMEM_BYTES, default 8192, instruction-memory size in bytes (2048 words).
REQ-003 Clocking is a single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 stall_if  in  1  hold PC; do not advance fetch.
REQ-007 stall_id  in  1  hold IF/ID register contents.
REQ-008 branch_flag  in  1  redirect next fetch to branch_target.
REQ-009 branch_target  in  32  redirect byte address.
REQ-010 flush  in  1  exception/flush; redirect to new_pc and squash IF/ID.
REQ-011 new_pc  in  32  exception/flush redirect byte address.
REQ-012 rom_inst  in  32  instruction word from combinational instruction memory.
REQ-013 rom_ce  out  1  instruction-memory chip enable (registered).
REQ-014 rom_addr  out  32  byte address to instruction memory, equal to current pc.
REQ-015 id_pc  out  32  PC of the instruction held in IF/ID.
REQ-016 id_inst  out  32  instruction held in IF/ID.
REQ-017 id_fetch_err  out  1  IF/ID entry is a misaligned or out-of-range fetch.
REQ-018 fetch_count  out  32  count of valid instructions delivered to IF/ID.

Function
REQ-019 State machine: RESET (rom_ce=0), START (rom_ce=0, one cycle), RUN (rom_ce=1).
- Transitions: any edge with rst=1 -> RESET; RESET -> START and START -> RUN on edges with rst=0; RUN persists until rst.
REQ-020 The PC register shall update only in RUN, with priority:
- flush -> pc <= new_pc;
- else stall_if -> hold;
- else branch_flag -> pc <= branch_target;
- else pc <= pc + 4, modulo 2^32.
REQ-021 branch_flag is ignored in any cycle where stall_if=1; the upstream stage holds it asserted until accepted.
REQ-022 rom_addr shall be driven combinationally from pc; rom_inst is sampled in the same cycle (zero-latency memory).
REQ-023 The IF/ID register shall update with priority:
- flush, or state != RUN -> bubble (id_pc=0, id_inst=0, id_fetch_err=0);
- else stall_id -> hold;
- else stall_if -> bubble;
- else capture id_pc<=pc, id_inst<=rom_inst, id_fetch_err<=fetch error.
REQ-024 Fetch error is true when pc[1:0]!=0 or pc>=IMEM_BYTES; on error id_inst shall be 0 (NOP) regardless of rom_inst.
REQ-025 fetch_count shall increment by 1 on each capture, including a capture with a fetch error, and shall wrap 32'hFFFF_FFFF -> 0.
REQ-026 Simultaneous flush and stall_if/stall_id: flush wins for both PC and IF/ID.
REQ-027 End-to-end latency: an instruction at pc appears on id_inst one edge after it is fetched with no stall.

Reset
REQ-028 On any edge with rst=1, the unit shall set: pc=RESET_PC, rom_ce=0, state=RESET, id_pc=0, id_inst=0, id_fetch_err=0, fetch_count=0.
REQ-029 rst asserted mid-operation shall override all other inputs at that edge.
REQ-030 The first capture into IF/ID occurs at the edge ending the first RUN cycle, delivering RESET_PC.

Verification
REQ-031 Reset release, memory word[i]=i, no stalls -> rom_ce rises 2 edges after rst falls; id_pc sequence 0,4,8,...; id_inst 0,1,2; fetch_count increments each edge.
REQ-032 Two-cycle stall_if with stall_id=0 at pc=0x10 -> pc held at 0x10; two bubbles in IF/ID; then id_pc=0x10; no instruction skipped or duplicated.
REQ-033 stall_id=1 for 3 cycles -> id_pc and id_inst frozen; fetch_count unchanged.
REQ-034 branch_flag=1, branch_target=0x100, concurrent with stall_if=1 for one cycle, then stall_if=0 -> branch honoured only after the stall clears; next id_pc=0x100.
REQ-035 flush=1, new_pc=0x20, concurrent with stall_if=1 and stall_id=1 -> IF/ID bubbled; pc=0x20; next capture id_pc=0x20.
REQ-036 branch_target=0x102, then separately 0x2000 with IMEM_BYTES=8192 -> id_fetch_err=1, id_inst=0; fetch_count still increments.
